// File: rtl/axil_lsu_param.sv
// ============================================================================
//  Module   : axil_lsu_param
//  Brief    : AXI4-Lite master load/store unit with byte-lane placement,
//             load extension, misalignment detection and handshake timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_lsu_param #(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter int         TIMEOUT = 255,
    parameter logic [2:0] PROT    = 3'b000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                W_R,
    input  logic [1:0]          wordsize,
    input  logic                signo,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                done,
    output logic                align,
    output logic                err,
    output logic [ADDR_W-1:0]   ARaddr,
    output logic                ARvalid,
    input  logic                ARready,
    output logic [2:0]          ARprot,
    input  logic [DATA_W-1:0]   Rdata,
    input  logic                Rvalid,
    output logic                RReady,
    output logic [ADDR_W-1:0]   AWaddr,
    output logic                AWvalid,
    input  logic                AWready,
    output logic [2:0]          AWprot,
    output logic [DATA_W-1:0]   Wdata,
    output logic [DATA_W/8-1:0] Wstrb,
    output logic                Wvalid,
    input  logic                Wready,
    input  logic                Bvalid,
    output logic                Bready
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_LANE_W = $clog2(c_STRB_W);
    localparam int c_TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_signo;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_aw_done;
    logic                r_w_done;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_align;
    logic                r_err;

    logic                w_misal;
    logic                w_busy;
    logic                w_abort;
    logic                w_tmo_hit;
    logic [c_LANE_W-1:0] w_offset;
    logic [c_LANE_W+2:0] w_shift;
    logic [DATA_W-1:0]   w_dmask;
    logic [c_STRB_W-1:0] w_smask;
    logic [DATA_W-1:0]   w_rshift;
    logic                w_sign;
    logic [DATA_W-1:0]   w_rdata_ext;

    // Dword requests are illegal on a 32-bit bus and are reported as misaligned.
    always_comb begin
        case (wordsize)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = addr[0];
            2'b10:   w_misal = |addr[1:0];
            default: w_misal = (|addr[2:0]) || (DATA_W < 64);
        endcase
    end

    assign w_offset = r_addr[c_LANE_W-1:0];
    assign w_shift  = {w_offset, 3'b000};

    always_comb begin
        w_dmask = '0;
        w_smask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_dmask[i] = (i < (8 << r_size));
        end
        for (int i = 0; i < c_STRB_W; i++) begin
            w_smask[i] = (i < (1 << r_size));
        end
    end

    assign w_rshift = Rdata >> w_shift;

    always_comb begin
        case (r_size)
            2'b00:   w_sign = w_rshift[7];
            2'b01:   w_sign = w_rshift[15];
            2'b10:   w_sign = w_rshift[31];
            default: w_sign = w_rshift[DATA_W-1];
        endcase
    end

    assign w_rdata_ext = (w_rshift & w_dmask) | ((r_signo && w_sign) ? ~w_dmask : '0);
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
    assign w_busy      = (r_state == S_RADDR) || (r_state == S_RDATA) ||
                         (r_state == S_WRITE) || (r_state == S_WRESP);

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    if (w_misal)  w_state_nxt = S_DONE;
                    else if (W_R) w_state_nxt = S_WRITE;
                    else          w_state_nxt = S_RADDR;
                end
            end
            S_RADDR: begin
                if (ARready)        w_state_nxt = S_RDATA;
                else if (w_tmo_hit) w_abort     = 1'b1;
            end
            S_RDATA: begin
                if (Rvalid)         w_state_nxt = S_DONE;
                else if (w_tmo_hit) w_abort     = 1'b1;
            end
            S_WRITE: begin
                if ((r_aw_done || AWready) && (r_w_done || Wready)) w_state_nxt = S_WRESP;
                else if (w_tmo_hit)                                 w_abort     = 1'b1;
            end
            S_WRESP: begin
                if (Bvalid)         w_state_nxt = S_DONE;
                else if (w_tmo_hit) w_abort     = 1'b1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_signo   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_tmo     <= '0;
            r_rdata   <= '0;
            r_align   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_tmo <= '0;
            else if (w_busy)            r_tmo <= r_tmo + 1'b1;

            if (r_state == S_IDLE && en) begin
                r_we      <= W_R;
                r_size    <= wordsize;
                r_signo   <= signo;
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_align   <= w_misal;
                r_err     <= 1'b0;
                r_rdata   <= '0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (r_state == S_WRITE) begin
                if (AWready) r_aw_done <= 1'b1;
                if (Wready)  r_w_done  <= 1'b1;
            end
            if (r_state == S_RDATA && Rvalid) r_rdata <= w_rdata_ext;
            if (w_abort)                      r_err   <= 1'b1;
        end
    end

    assign busy    = w_busy;
    assign done    = (r_state == S_DONE);
    assign rdata   = done ? r_rdata : '0;
    assign align   = done && r_align;
    assign err     = done && r_err;

    assign ARaddr  = {r_addr[ADDR_W-1:c_LANE_W], {c_LANE_W{1'b0}}};
    assign AWaddr  = {r_addr[ADDR_W-1:c_LANE_W], {c_LANE_W{1'b0}}};
    assign ARprot  = PROT;
    assign AWprot  = PROT;
    assign ARvalid = (r_state == S_RADDR);
    assign RReady  = (r_state == S_RDATA);
    assign AWvalid = (r_state == S_WRITE) && !r_aw_done && r_we;
    assign Wvalid  = (r_state == S_WRITE) && !r_w_done && r_we;
    assign Wdata   = (r_wdata & w_dmask) << w_shift;
    assign Wstrb   = w_smask << w_offset;
    assign Bready  = (r_state == S_WRESP);

endmodule

`default_nettype wire

// File: tb/tb_axil_lsu_param.sv
// ============================================================================
//  Module   : tb_axil_lsu_param
//  Brief    : Directed bench for axil_lsu_param on 32-bit and 64-bit buses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_lsu_param;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 32-bit instance, short timeout
    logic        a_en, a_wr, a_signo, a_busy, a_done, a_align, a_err;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_rdata, a_araddr, a_awaddr, a_rbus, a_wbus;
    logic        a_arvalid, a_arready, a_rvalid, a_rready, a_awvalid, a_awready;
    logic        a_wvalid, a_wready, a_bvalid, a_bready;
    logic [2:0]  a_arprot, a_awprot;
    logic [3:0]  a_wstrb;

    // 64-bit instance
    logic        b_en, b_wr, b_signo, b_busy, b_done, b_align, b_err;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_araddr, b_awaddr;
    logic [63:0] b_wdata, b_rdata, b_rbus, b_wbus;
    logic        b_arvalid, b_arready, b_rvalid, b_rready, b_awvalid, b_awready;
    logic        b_wvalid, b_wready, b_bvalid, b_bready;
    logic [2:0]  b_arprot, b_awprot;
    logic [7:0]  b_wstrb;

    axil_lsu_param #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .PROT(3'b101)) u_a (
        .clk(clk), .rstn(rstn), .en(a_en), .W_R(a_wr), .wordsize(a_size), .signo(a_signo),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .busy(a_busy), .done(a_done),
        .align(a_align), .err(a_err), .ARaddr(a_araddr), .ARvalid(a_arvalid),
        .ARready(a_arready), .ARprot(a_arprot), .Rdata(a_rbus), .Rvalid(a_rvalid),
        .RReady(a_rready), .AWaddr(a_awaddr), .AWvalid(a_awvalid), .AWready(a_awready),
        .AWprot(a_awprot), .Wdata(a_wbus), .Wstrb(a_wstrb), .Wvalid(a_wvalid),
        .Wready(a_wready), .Bvalid(a_bvalid), .Bready(a_bready)
    );

    axil_lsu_param #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(8), .PROT(3'b000)) u_b (
        .clk(clk), .rstn(rstn), .en(b_en), .W_R(b_wr), .wordsize(b_size), .signo(b_signo),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .busy(b_busy), .done(b_done),
        .align(b_align), .err(b_err), .ARaddr(b_araddr), .ARvalid(b_arvalid),
        .ARready(b_arready), .ARprot(b_arprot), .Rdata(b_rbus), .Rvalid(b_rvalid),
        .RReady(b_rready), .AWaddr(b_awaddr), .AWvalid(b_awvalid), .AWready(b_awready),
        .AWprot(b_awprot), .Wdata(b_wbus), .Wstrb(b_wstrb), .Wvalid(b_wvalid),
        .Wready(b_wready), .Bvalid(b_bvalid), .Bready(b_bready)
    );

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", a_done); end
        checks++; if ({a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready} !== 5'b0) begin
            errors++; $display("FAIL reset_a_axi: got %b expected 00000", {a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready}); end
        checks++; if ({b_busy, b_done, b_arvalid, b_awvalid, b_wvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_b: got %b expected 00000", {b_busy, b_done, b_arvalid, b_awvalid, b_wvalid}); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        a_en = 1'b1; a_wr = 1'b0; a_size = 2'b00; a_signo = 1'b1; a_addr = 32'h103;
        @(negedge clk); a_en = 1'b0;
        checks++; if (a_arvalid !== 1'b1) begin errors++; $display("FAIL ldb_arvalid: got %b expected 1", a_arvalid); end
        checks++; if (a_araddr !== 32'h100) begin errors++; $display("FAIL ldb_araddr: got %h expected 00000100", a_araddr); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL ldb_busy: got %b expected 1", a_busy); end
        checks++; if (a_arprot !== 3'b101) begin errors++; $display("FAIL ldb_arprot: got %b expected 101", a_arprot); end
        a_arready = 1'b1;
        @(negedge clk); a_arready = 1'b0;
        checks++; if ({a_arvalid, a_rready} !== 2'b01) begin errors++; $display("FAIL ldb_rphase: got %b expected 01", {a_arvalid, a_rready}); end
        a_rvalid = 1'b1; a_rbus = 32'h8000_0000;
        @(negedge clk); a_rvalid = 1'b0; a_rbus = '0;
        checks++; if ({a_done, a_busy} !== 2'b10) begin errors++; $display("FAIL ldb_done: got %b expected 10", {a_done, a_busy}); end
        checks++; if (a_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_rdata: got %h expected ffffff80", a_rdata); end
        @(negedge clk);
        checks++; if ({a_done, a_rdata} !== 33'h0) begin errors++; $display("FAIL ldb_after: got %h expected 0", {a_done, a_rdata}); end
    endtask

    task automatic test_store_half();
        a_en = 1'b1; a_wr = 1'b1; a_size = 2'b01; a_signo = 1'b0; a_addr = 32'h202; a_wdata = 32'h1234;
        @(negedge clk); a_en = 1'b0;
        checks++; if ({a_awvalid, a_wvalid} !== 2'b11) begin errors++; $display("FAIL sth_valids: got %b expected 11", {a_awvalid, a_wvalid}); end
        checks++; if (a_wbus !== 32'h1234_0000) begin errors++; $display("FAIL sth_wdata: got %h expected 12340000", a_wbus); end
        checks++; if (a_wstrb !== 4'b1100) begin errors++; $display("FAIL sth_wstrb: got %b expected 1100", a_wstrb); end
        checks++; if (a_awaddr !== 32'h200) begin errors++; $display("FAIL sth_awaddr: got %h expected 00000200", a_awaddr); end
        a_awready = 1'b1;
        @(negedge clk); a_awready = 1'b0;
        checks++; if ({a_awvalid, a_wvalid} !== 2'b01) begin errors++; $display("FAIL sth_aw_drop: got %b expected 01", {a_awvalid, a_wvalid}); end
        @(negedge clk);
        checks++; if (a_wvalid !== 1'b1) begin errors++; $display("FAIL sth_w_hold: got %b expected 1", a_wvalid); end
        a_wready = 1'b1;
        @(negedge clk); a_wready = 1'b0;
        checks++; if ({a_wvalid, a_bready, a_busy} !== 3'b011) begin errors++; $display("FAIL sth_wresp: got %b expected 011", {a_wvalid, a_bready, a_busy}); end
        a_bvalid = 1'b1;
        @(negedge clk); a_bvalid = 1'b0;
        checks++; if ({a_done, a_err, a_align} !== 3'b100) begin errors++; $display("FAIL sth_done: got %b expected 100", {a_done, a_err, a_align}); end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        a_en = 1'b1; a_wr = 1'b0; a_size = 2'b10; a_addr = 32'h5;
        @(negedge clk); a_en = 1'b0;
        checks++; if ({a_done, a_align, a_arvalid, a_busy} !== 4'b1100) begin
            errors++; $display("FAIL mis_word: got %b expected 1100", {a_done, a_align, a_arvalid, a_busy}); end
        @(negedge clk);
        checks++; if ({a_done, a_align} !== 2'b00) begin errors++; $display("FAIL mis_clear: got %b expected 00", {a_done, a_align}); end
        a_en = 1'b1; a_wr = 1'b1; a_size = 2'b11; a_addr = 32'h0;
        @(negedge clk); a_en = 1'b0;
        checks++; if ({a_done, a_align, a_awvalid, a_wvalid} !== 4'b1100) begin
            errors++; $display("FAIL mis_dword32: got %b expected 1100", {a_done, a_align, a_awvalid, a_wvalid}); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        a_en = 1'b1; a_wr = 1'b0; a_size = 2'b10; a_addr = 32'h40;
        @(negedge clk); a_en = 1'b0;
        n = 0;
        while (a_arvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL tmo_cycles: got %0d expected 8", n); end
        checks++; if ({a_done, a_err, a_busy, a_arvalid} !== 4'b1100) begin
            errors++; $display("FAIL tmo_done: got %b expected 1100", {a_done, a_err, a_busy, a_arvalid}); end
        @(negedge clk);
        a_arready = 1'b1; a_rvalid = 1'b1;
        @(negedge clk); a_arready = 1'b0; a_rvalid = 1'b0;
        checks++; if ({a_busy, a_done, a_err, a_rready} !== 4'b0) begin
            errors++; $display("FAIL tmo_late: got %b expected 0000", {a_busy, a_done, a_err, a_rready}); end
    endtask

    task automatic test_reset_mid_write();
        a_en = 1'b1; a_wr = 1'b1; a_size = 2'b10; a_addr = 32'h300; a_wdata = 32'hCAFE_F00D;
        @(negedge clk); a_en = 1'b0;
        checks++; if (a_awvalid !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b expected 1", a_awvalid); end
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        checks++; if ({a_awvalid, a_wvalid, a_busy} !== 3'b000) begin
            errors++; $display("FAIL rst_drop: got %b expected 000", {a_awvalid, a_wvalid, a_busy}); end
        a_en = 1'b1; a_wr = 1'b0; a_size = 2'b01; a_signo = 1'b0; a_addr = 32'h302;
        @(negedge clk); a_en = 1'b0;
        checks++; if (a_araddr !== 32'h300) begin errors++; $display("FAIL rst_araddr: got %h expected 00000300", a_araddr); end
        a_arready = 1'b1;
        @(negedge clk); a_arready = 1'b0;
        a_rvalid = 1'b1; a_rbus = 32'hBEEF_0000;
        @(negedge clk); a_rvalid = 1'b0;
        checks++; if ({a_done, a_rdata} !== {1'b1, 32'h0000_BEEF}) begin
            errors++; $display("FAIL rst_reload: got %h expected 10000beef", {a_done, a_rdata}); end
        @(negedge clk);
    endtask

    task automatic test_wide_bus();
        b_en = 1'b1; b_wr = 1'b1; b_size = 2'b11; b_addr = 32'h18; b_wdata = 64'h1122_3344_5566_7788;
        @(negedge clk); b_en = 1'b0;
        checks++; if (b_wstrb !== 8'hFF) begin errors++; $display("FAIL w64_strb: got %h expected ff", b_wstrb); end
        checks++; if (b_wbus !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL w64_wdata: got %h expected 1122334455667788", b_wbus); end
        b_awready = 1'b1; b_wready = 1'b1;
        @(negedge clk); b_awready = 1'b0; b_wready = 1'b0;
        checks++; if ({b_awvalid, b_wvalid, b_bready} !== 3'b001) begin
            errors++; $display("FAIL w64_same_cycle: got %b expected 001", {b_awvalid, b_wvalid, b_bready}); end
        b_bvalid = 1'b1;
        @(negedge clk); b_bvalid = 1'b0;
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL w64_done: got %b expected 1", b_done); end
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            b_en = 1'b1; b_wr = 1'b0; b_size = 2'b01; b_signo = (k == 1); b_addr = 32'h1E;
            @(negedge clk); b_en = 1'b0;
            checks++; if (b_araddr !== 32'h18) begin errors++; $display("FAIL r64_araddr: got %h expected 00000018", b_araddr); end
            b_arready = 1'b1;
            @(negedge clk); b_arready = 1'b0;
            b_rvalid = 1'b1; b_rbus = 64'hBEEF_0000_0000_0000;
            @(negedge clk); b_rvalid = 1'b0;
            if (k == 0) begin
                checks++; if (b_rdata !== 64'h0000_0000_0000_BEEF) begin errors++; $display("FAIL r64_zext: got %h expected 000000000000beef", b_rdata); end
            end else begin
                checks++; if (b_rdata !== 64'hFFFF_FFFF_FFFF_BEEF) begin errors++; $display("FAIL r64_sext: got %h expected ffffffffffffbeef", b_rdata); end
            end
            @(negedge clk);
        end

        b_en = 1'b1; b_wr = 1'b1; b_size = 2'b00; b_addr = 32'h1D; b_wdata = 64'hAB;
        @(negedge clk); b_en = 1'b0;
        checks++; if (b_wstrb !== 8'h20) begin errors++; $display("FAIL w64b_strb: got %h expected 20", b_wstrb); end
        checks++; if (b_wbus !== 64'h0000_AB00_0000_0000) begin errors++; $display("FAIL w64b_wdata: got %h expected 0000ab0000000000", b_wbus); end
        b_awready = 1'b1; b_wready = 1'b1;
        @(negedge clk); b_awready = 1'b0; b_wready = 1'b0; b_bvalid = 1'b1;
        @(negedge clk); b_bvalid = 1'b0;
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL w64b_done: got %b expected 1", b_done); end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        a_en = 0; a_wr = 0; a_size = 0; a_signo = 0; a_addr = 0; a_wdata = 0; a_rbus = 0;
        a_arready = 0; a_rvalid = 0; a_awready = 0; a_wready = 0; a_bvalid = 0;
        b_en = 0; b_wr = 0; b_size = 0; b_signo = 0; b_addr = 0; b_wdata = 0; b_rbus = 0;
        b_arready = 0; b_rvalid = 0; b_awready = 0; b_wready = 0; b_bvalid = 0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_mid_write();
        test_wide_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
